// File: rtl/prog_ctr_pkg.sv
// Shared types and defaults for the program-counter / fetch-sequencing stage.
package prog_ctr_pkg;

  localparam int unsigned PW = 10;
  localparam int unsigned CW = 16;

  localparam logic [PW-1:0] DefBase0 = 10'd0;
  localparam logic [PW-1:0] DefBase1 = 10'd256;
  localparam logic [PW-1:0] DefBase2 = 10'd512;
  localparam logic [PW-1:0] DefBase3 = 10'd768;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE run control, next-PC mux
// (restart, halt, stall, branch, sequential) and a saturating RUN cycle counter.
module prog_ctr_fetch #(
  parameter int unsigned    PW    = prog_ctr_pkg::PW,
  parameter int unsigned    CW    = prog_ctr_pkg::CW,
  parameter logic [PW-1:0] BASE0 = prog_ctr_pkg::DefBase0,
  parameter logic [PW-1:0] BASE1 = prog_ctr_pkg::DefBase1,
  parameter logic [PW-1:0] BASE2 = prog_ctr_pkg::DefBase2,
  parameter logic [PW-1:0] BASE3 = prog_ctr_pkg::DefBase3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          Stall,
  input  logic          BrTaken,
  input  logic [PW-1:0] Target,
  input  logic          Halt,
  output logic [PW-1:0] ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCnt
);

  import prog_ctr_pkg::*;

  fetch_state_t  state_d, state_q;
  logic [PW-1:0] pc_d, pc_q;
  logic [PW-1:0] base_sel;
  logic          running_q, done_q;
  logic          cnt_clr, cnt_en;

  always_comb begin
    case (ProgSel)
      2'd0:    base_sel = BASE0;
      2'd1:    base_sel = BASE1;
      2'd2:    base_sel = BASE2;
      default: base_sel = BASE3;
    endcase
  end

  // Target/BrTaken are only looked at in the lowest-priority RUN branch so an
  // undriven Target outside that case never reaches the PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (Start) begin
      state_d = StRun;
      pc_d    = base_sel;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: ;
        StRun: begin
          cnt_en = 1'b1;
          if (Halt) begin
            state_d = StDone;
          end else if (Stall) begin
            pc_d = pc_q;
          end else if (BrTaken) begin
            pc_d = Target;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  sat_counter #(
    .Width(CW)
  ) u_cycle_cnt (
    .clk_i(Clk),
    .rst_i(Reset),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .cnt_o(CycleCnt)
  );

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule
